adder_half_1bit: RTL and testbench

//   1-bit half adder: sum = a XOR b, carry = a AND b.
//   - Primary outputs are purely combinational and drop-in compatible with

---
 rtl/adder_half_1bit.sv | 65 ++++++
 tb/tb_adder_half_1bit.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/adder_half_1bit.sv
// 1-bit half adder with zero-latency outputs, plus a registered side path that
// delays {carry, sum} by PIPE_STAGES edges and counts carry cycles, saturating.
module adder_half_1bit #(
  parameter int PIPE_STAGES = 1,
  parameter int CNT_WIDTH   = 8
) (
  output logic                 output_carry,
  output logic                 output_sum,
  input  logic                 input_a,
  input  logic                 input_b,
  input  logic                 Clk,
  input  logic                 Rst,
  output logic                 carry_q,
  output logic                 sum_q,
  output logic [CNT_WIDTH-1:0] carry_count
);

  if (PIPE_STAGES < 1 || PIPE_STAGES > 8) begin : g_bad_pipe_stages
    $error("adder_half_1bit: PIPE_STAGES=%0d outside 1..8", PIPE_STAGES);
  end
  if (CNT_WIDTH < 1 || CNT_WIDTH > 32) begin : g_bad_cnt_width
    $error("adder_half_1bit: CNT_WIDTH=%0d outside 1..32", CNT_WIDTH);
  end

  // The primary outputs never touch Clk/Rst, so they stay valid with those unconnected.
  assign output_sum   = input_a ^ input_b;
  assign output_carry = input_a & input_b;

  logic [1:0]           pipe_q [PIPE_STAGES];
  logic [1:0]           pipe_d [PIPE_STAGES];
  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] count_d;

  // NOTE: every variable is given a default first so no path through the block can infer a latch.
  always_comb begin
    pipe_d[0] = {output_carry, output_sum};
    for (int i = 1; i < PIPE_STAGES; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
    count_d = count_q;
    if (output_carry && (count_q != {CNT_WIDTH{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: the pipeline array is reset element by element because a mid-run reset must flush in-flight data.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < PIPE_STAGES; i++) begin
        pipe_q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments give every stage the pre-edge value of its neighbour.
      for (int i = 0; i < PIPE_STAGES; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
      count_q <= count_d;
    end
  end

  assign {carry_q, sum_q} = pipe_q[PIPE_STAGES-1];
  assign carry_count      = count_q;

endmodule

// File: tb/tb_adder_half_1bit.sv
// Randomized and directed scoreboard bench for adder_half_1bit: two clocked
// instances (1-stage/8-bit counter, 4-stage/2-bit counter) and one unclocked.
module tb_adder_half_1bit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic a, b, rst;
  logic ca, cb, nc_clk, nc_rst;

  logic       d1_carry, d1_sum, d1_carry_q, d1_sum_q;
  logic [7:0] d1_cnt;
  logic       d4_carry, d4_sum, d4_carry_q, d4_sum_q;
  logic [1:0] d4_cnt;
  logic       u_carry, u_sum, u_carry_q, u_sum_q;
  logic [7:0] u_cnt;

  adder_half_1bit #(.PIPE_STAGES(1), .CNT_WIDTH(8)) dut1 (
    .output_carry(d1_carry), .output_sum(d1_sum), .input_a(a), .input_b(b),
    .Clk(clk), .Rst(rst), .carry_q(d1_carry_q), .sum_q(d1_sum_q), .carry_count(d1_cnt));

  adder_half_1bit #(.PIPE_STAGES(4), .CNT_WIDTH(2)) dut4 (
    .output_carry(d4_carry), .output_sum(d4_sum), .input_a(a), .input_b(b),
    .Clk(clk), .Rst(rst), .carry_q(d4_carry_q), .sum_q(d4_sum_q), .carry_count(d4_cnt));

  adder_half_1bit #(.PIPE_STAGES(1), .CNT_WIDTH(8)) u_comb (
    .output_carry(u_carry), .output_sum(u_sum), .input_a(ca), .input_b(cb),
    .Clk(nc_clk), .Rst(nc_rst), .carry_q(u_carry_q), .sum_q(u_sum_q), .carry_count(u_cnt));

  typedef struct {
    logic       comb_carry, comb_sum;
    logic       c1, s1;
    logic [7:0] n1;
    logic       c4, s4;
    logic [1:0] n4;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model state: operand pairs seen since the last reset, and carry total.
  logic [1:0] hist[$];
  int         carries = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, actual, expected);
  endtask

  // Value of a&b / a^b for the pair sampled `depth` edges ago; zero if reset is more recent.
  function automatic logic [1:0] delayed(input int depth);
    logic [1:0] p;
    if (hist.size() < depth) return 2'b00;
    p = hist[hist.size() - depth];
    return {p[1] & p[0], p[1] ^ p[0]};
  endfunction

  task automatic cycle(input logic ai, input logic bi, input logic ri);
    exp_t       e;
    logic [1:0] d;
    @(negedge clk);
    a = ai; b = bi; rst = ri;
    if (ri) begin
      hist.delete();
      carries = 0;
    end else begin
      hist.push_back({ai, bi});
      if (hist.size() > 8) void'(hist.pop_front());
      if (ai && bi) carries++;
    end
    e.comb_carry = ai & bi;
    e.comb_sum   = ai ^ bi;
    d = delayed(1); e.c1 = d[1]; e.s1 = d[0];
    d = delayed(4); e.c4 = d[1]; e.s4 = d[0];
    e.n1 = (carries > 255) ? 8'd255 : 8'(carries);
    e.n4 = (carries > 3)   ? 2'd3   : 2'(carries);
    sb.push_back(e);
  endtask

  // Monitor: the DUT presents a result after every edge; compare against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("d1_comb_carry", int'(d1_carry),   int'(e.comb_carry));
        check("d1_comb_sum",   int'(d1_sum),     int'(e.comb_sum));
        check("d1_carry_q",    int'(d1_carry_q), int'(e.c1));
        check("d1_sum_q",      int'(d1_sum_q),   int'(e.s1));
        check("d1_count",      int'(d1_cnt),     int'(e.n1));
        check("d4_carry_q",    int'(d4_carry_q), int'(e.c4));
        check("d4_sum_q",      int'(d4_sum_q),   int'(e.s4));
        check("d4_count",      int'(d4_cnt),     int'(e.n4));
      end
    end
  end

  initial begin
    a = 0; b = 0; rst = 0; ca = 0; cb = 0;
    nc_clk = 1'bx; nc_rst = 1'bx;

    // Combinational sweep on the unclocked instance.
    for (int i = 0; i < 4; i++) begin
      ca = i[0]; cb = i[1];
      #10;
      check($sformatf("comb_carry_ab%0d%0d", ca, cb), int'(u_carry), int'(ca & cb));
      check($sformatf("comb_sum_ab%0d%0d", ca, cb),   int'(u_sum),   int'(ca ^ cb));
    end

    // Latency of a single carry pulse.
    cycle(0, 0, 1);
    cycle(1, 1, 0);
    cycle(0, 0, 0);
    cycle(0, 0, 0);

    // Counter: five carry cycles then idle.
    cycle(0, 0, 1);
    repeat (5) cycle(1, 1, 0);
    repeat (3) cycle(0, 1, 0);

    // Saturation of the 2-bit counter (and steady growth of the 8-bit one).
    cycle(0, 0, 1);
    repeat (6) cycle(1, 1, 0);
    repeat (2) cycle(1, 0, 0);

    // Reset mid-operation with count 4 and pipelines full of carries.
    cycle(0, 0, 1);
    repeat (4) cycle(1, 1, 0);
    cycle(1, 1, 1);
    cycle(1, 1, 0);
    repeat (5) cycle(0, 0, 0);

    // Single sum pulse through the deep pipeline.
    cycle(0, 0, 1);
    cycle(1, 0, 0);
    repeat (6) cycle(0, 0, 0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom), 1'($urandom), ($urandom_range(0, 24) == 0));
    end
    repeat (300) cycle(1, 1, 0);

    @(posedge clk);
    #3;
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
